// File: rtl/oc_alloc_ctrl_if.sv
// rtl/oc_alloc_ctrl_if.sv - Issue, RF response, EX grant and flush signals of the operand-collector allocator
interface oc_alloc_ctrl_if #(
  parameter int WARP_ID_W = 3
);
  logic                 Iss_Valid;
  logic [WARP_ID_W-1:0] Iss_Warp_ID;
  logic [2:0]           Iss_Src_Valid;
  logic                 Iss_Ready;
  logic [1:0]           Alloc_Entry;
  logic                 RF_Rsp_Valid;
  logic [1:0]           RF_Rsp_Entry;
  logic [1:0]           RF_Rsp_Src;
  logic [3:0]           OC_IssReq_EX_IU;
  logic [3:0]           EX_IU_Grant;
  logic                 Flush_Valid;
  logic [WARP_ID_W-1:0] Flush_Warp_ID;
  logic                 OC_Err;

  modport master (
    output Iss_Valid, Iss_Warp_ID, Iss_Src_Valid,
    input  Iss_Ready, Alloc_Entry,
    output RF_Rsp_Valid, RF_Rsp_Entry, RF_Rsp_Src,
    input  OC_IssReq_EX_IU,
    output EX_IU_Grant, Flush_Valid, Flush_Warp_ID,
    input  OC_Err
  );

  modport slave (
    input  Iss_Valid, Iss_Warp_ID, Iss_Src_Valid,
    output Iss_Ready, Alloc_Entry,
    input  RF_Rsp_Valid, RF_Rsp_Entry, RF_Rsp_Src,
    output OC_IssReq_EX_IU,
    input  EX_IU_Grant, Flush_Valid, Flush_Warp_ID,
    output OC_Err
  );
endinterface

// File: rtl/oc_alloc_ctrl.sv
// rtl/oc_alloc_ctrl.sv - Four-entry operand-collector allocator with operand tracking, issue request and warp flush
module oc_alloc_ctrl #(
  parameter int WARP_ID_W = 3
) (
  input logic            clk,
  input logic            rst_n,
  oc_alloc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_FREE       = 2'd0,
    ST_COLLECTING = 2'd1,
    ST_READY      = 2'd2
  } entry_state_e;

  entry_state_e         r_state       [4];
  entry_state_e         w_state_nxt   [4];
  logic [2:0]           r_pending     [4];
  logic [2:0]           w_pending_nxt [4];
  logic [WARP_ID_W-1:0] r_warp        [4];
  logic [WARP_ID_W-1:0] w_warp_nxt    [4];
  logic                 r_err;
  logic                 w_err_nxt;

  logic [3:0] w_free;
  logic [3:0] w_req;
  logic [1:0] w_alloc_idx;
  logic       w_accept;
  logic [3:0] w_flush_hit;
  logic       w_grant_ok;
  logic       w_grant_err;
  logic [2:0] w_rsp_mask;
  logic       w_rsp_hit;
  logic       w_rsp_err;

  // Outputs depend only on registered entry state.
  always_comb begin
    w_free      = '0;
    w_req       = '0;
    w_alloc_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      w_free[i] = (r_state[i] == ST_FREE);
      w_req[i]  = (r_state[i] == ST_READY);
    end
    for (int i = 3; i >= 0; i--) begin
      if (w_free[i]) begin
        w_alloc_idx = 2'(i);
      end
    end
  end

  assign bus.Iss_Ready       = |w_free;
  assign bus.Alloc_Entry     = w_alloc_idx;
  assign bus.OC_IssReq_EX_IU = w_req;
  assign bus.OC_Err          = r_err;

  assign w_accept = bus.Iss_Valid & (|w_free);

  // Flush only reaches entries that were already occupied, so a same-cycle allocation survives.
  always_comb begin
    w_flush_hit = '0;
    for (int i = 0; i < 4; i++) begin
      w_flush_hit[i] = bus.Flush_Valid && (r_state[i] != ST_FREE) &&
                       (r_warp[i] == bus.Flush_Warp_ID);
    end
  end

  assign w_grant_ok  = ((bus.EX_IU_Grant & (bus.EX_IU_Grant - 4'd1)) == 4'd0);
  assign w_grant_err = !w_grant_ok || ((bus.EX_IU_Grant & ~w_req & ~w_flush_hit) != 4'd0);

  // Source 3 shifts out of the mask, so it can never match a pending bit.
  assign w_rsp_mask = 3'b001 << bus.RF_Rsp_Src;
  assign w_rsp_hit  = bus.RF_Rsp_Valid &&
                      (r_state[bus.RF_Rsp_Entry] == ST_COLLECTING) &&
                      ((r_pending[bus.RF_Rsp_Entry] & w_rsp_mask) != 3'b000);
  assign w_rsp_err  = bus.RF_Rsp_Valid &&
                      ((bus.RF_Rsp_Src == 2'd3) ||
                       (!w_rsp_hit && !w_flush_hit[bus.RF_Rsp_Entry]));

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_state_nxt[i]   = r_state[i];
      w_pending_nxt[i] = r_pending[i];
      w_warp_nxt[i]    = r_warp[i];
      if (w_flush_hit[i]) begin
        w_state_nxt[i]   = ST_FREE;
        w_pending_nxt[i] = 3'b000;
      end else if (w_grant_ok && bus.EX_IU_Grant[i] && (r_state[i] == ST_READY)) begin
        w_state_nxt[i]   = ST_FREE;
        w_pending_nxt[i] = 3'b000;
      end else if (w_rsp_hit && (bus.RF_Rsp_Entry == 2'(i))) begin
        w_pending_nxt[i] = r_pending[i] & ~w_rsp_mask;
        if ((r_pending[i] & ~w_rsp_mask) == 3'b000) begin
          w_state_nxt[i] = ST_READY;
        end
      end else if (w_accept && (w_alloc_idx == 2'(i))) begin
        w_warp_nxt[i]    = bus.Iss_Warp_ID;
        w_pending_nxt[i] = bus.Iss_Src_Valid;
        w_state_nxt[i]   = (bus.Iss_Src_Valid != 3'b000) ? ST_COLLECTING : ST_READY;
      end
    end
    w_err_nxt = r_err | w_grant_err | w_rsp_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_state[i]   <= ST_FREE;
        r_pending[i] <= 3'b000;
        r_warp[i]    <= '0;
      end
      r_err <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_state[i]   <= w_state_nxt[i];
        r_pending[i] <= w_pending_nxt[i];
        r_warp[i]    <= w_warp_nxt[i];
      end
      r_err <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_oc_alloc_ctrl.sv
// tb/tb_oc_alloc_ctrl.sv - Scoreboard bench for oc_alloc_ctrl with directed allocation, response, grant and flush vectors
module tb_oc_alloc_ctrl;

  logic clk;
  logic rst_n;

  oc_alloc_ctrl_if #(.WARP_ID_W(3)) bus ();

  oc_alloc_ctrl #(.WARP_ID_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rdy;
    logic [1:0] al;
    logic [3:0] rq;
    logic       er;
  } exp_t;

  exp_t  exp_q [$];
  string nm_q  [$];
  int    n_checks;
  int    n_errors;
  exp_t  mon_e;
  string mon_nm;

  function automatic void chk(input string nm, input string fld, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, req);
    end
  endfunction

  // Monitor: pops one expected observation per cycle, mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = nm_q.pop_front();
      chk(mon_nm, "iss_ready", int'(bus.Iss_Ready), int'(mon_e.rdy));
      chk(mon_nm, "alloc_entry", int'(bus.Alloc_Entry), int'(mon_e.al));
      chk(mon_nm, "issreq", int'(bus.OC_IssReq_EX_IU), int'(mon_e.rq));
      chk(mon_nm, "oc_err", int'(bus.OC_Err), int'(mon_e.er));
    end
  end

  task automatic clear_inputs();
    bus.Iss_Valid     = 1'b0;
    bus.Iss_Warp_ID   = '0;
    bus.Iss_Src_Valid = '0;
    bus.RF_Rsp_Valid  = 1'b0;
    bus.RF_Rsp_Entry  = '0;
    bus.RF_Rsp_Src    = '0;
    bus.EX_IU_Grant   = '0;
    bus.Flush_Valid   = 1'b0;
    bus.Flush_Warp_ID = '0;
  endtask

  task automatic cyc(input string nm, input logic rdy, input logic [1:0] al,
                     input logic [3:0] rq, input logic er);
    exp_t e;
    e.rdy = rdy;
    e.al  = al;
    e.rq  = rq;
    e.er  = er;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic offer(input logic [2:0] w, input logic [2:0] src);
    bus.Iss_Valid     = 1'b1;
    bus.Iss_Warp_ID   = w;
    bus.Iss_Src_Valid = src;
  endtask

  task automatic rsp(input logic [1:0] e, input logic [1:0] s);
    bus.RF_Rsp_Valid = 1'b1;
    bus.RF_Rsp_Entry = e;
    bus.RF_Rsp_Src   = s;
  endtask

  task automatic grant(input logic [3:0] g);
    bus.EX_IU_Grant = g;
  endtask

  task automatic flush(input logic [2:0] w);
    bus.Flush_Valid   = 1'b1;
    bus.Flush_Warp_ID = w;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc("rst", 1'b1, 2'd0, 4'b0000, 1'b0);
    rst_n = 1'b1;
    cyc("rst_rel", 1'b1, 2'd0, 4'b0000, 1'b0);
  endtask

  logic [3:0] exp_r;
  int         ents [3];
  int         drain;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;
    do_reset();

    // Source-less instruction: request one cycle later, then retire.
    offer(3'd2, 3'b000); cyc("t1_offer", 1, 0, 4'b0000, 0);
    cyc("t1_req", 1, 1, 4'b0001, 0);
    grant(4'b0001); cyc("t1_grant", 1, 1, 4'b0001, 0);
    cyc("t1_freed", 1, 0, 4'b0000, 0);

    // Fill all four entries with three sources each.
    offer(3'd1, 3'b111); cyc("t2_a0", 1, 0, 4'b0000, 0);
    offer(3'd1, 3'b111); cyc("t2_a1", 1, 1, 4'b0000, 0);
    offer(3'd1, 3'b111); cyc("t2_a2", 1, 2, 4'b0000, 0);
    offer(3'd1, 3'b111); cyc("t2_a3", 1, 3, 4'b0000, 0);
    offer(3'd1, 3'b111); cyc("t2_full", 0, 0, 4'b0000, 0);
    rsp(2'd2, 2'd0); cyc("t2_r0", 0, 0, 4'b0000, 0);
    rsp(2'd2, 2'd1); cyc("t2_r1", 0, 0, 4'b0000, 0);
    rsp(2'd2, 2'd2); cyc("t2_r2", 0, 0, 4'b0000, 0);
    cyc("t2_e2rdy", 0, 0, 4'b0100, 0);

    // Complete every remaining entry, then grant entry 1 and reuse it.
    exp_r = 4'b0100;
    ents  = '{0, 1, 3};
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < 3; s++) begin
        rsp(2'(ents[k]), 2'(s));
        cyc("t3_fill", 0, 0, exp_r, 0);
      end
      exp_r[ents[k]] = 1'b1;
    end
    cyc("t3_allrdy", 0, 0, 4'b1111, 0);
    grant(4'b0010); cyc("t3_g1", 0, 0, 4'b1111, 0);
    cyc("t3_e1free", 1, 1, 4'b1101, 0);
    offer(3'd4, 3'b000); cyc("t3_realloc", 1, 1, 4'b1101, 0);
    cyc("t3_full", 0, 0, 4'b1111, 0);

    // Asynchronous reset in the middle of traffic.
    do_reset();

    // Flush warp 5: entries 0 (collecting) and 2 (ready) leave, entry 1 stays.
    offer(3'd5, 3'b001); cyc("t4_a0", 1, 0, 4'b0000, 0);
    offer(3'd3, 3'b010); cyc("t4_a1", 1, 1, 4'b0000, 0);
    offer(3'd5, 3'b000); cyc("t4_a2", 1, 2, 4'b0000, 0);
    cyc("t4_pre", 1, 3, 4'b0100, 0);
    flush(3'd5); cyc("t4_flush", 1, 3, 4'b0100, 0);
    cyc("t4_post", 1, 0, 4'b0000, 0);
    rsp(2'd1, 2'd1); cyc("t4_e1rsp", 1, 0, 4'b0000, 0);
    cyc("t4_e1rdy", 1, 0, 4'b0010, 0);
    offer(3'd5, 3'b000); flush(3'd5); cyc("t4_fl_alloc", 1, 0, 4'b0010, 0);
    cyc("t4_kept", 1, 2, 4'b0011, 0);

    // Entry 3 held READY while ungranted, then retired.
    offer(3'd6, 3'b000); cyc("t5_a2", 1, 2, 4'b0011, 0);
    offer(3'd6, 3'b000); cyc("t5_a3", 1, 3, 4'b0111, 0);
    cyc("t5_full", 0, 0, 4'b1111, 0);
    grant(4'b0001); cyc("t5_g0", 0, 0, 4'b1111, 0);
    grant(4'b0010); cyc("t5_g1", 1, 0, 4'b1110, 0);
    grant(4'b0100); cyc("t5_g2", 1, 0, 4'b1100, 0);
    for (int n = 0; n < 5; n++) begin
      cyc("t5_hold", 1, 0, 4'b1000, 0);
    end
    grant(4'b1000); cyc("t5_g3", 1, 0, 4'b1000, 0);
    cyc("t5_done", 1, 0, 4'b0000, 0);

    // Response to a FREE entry and a multi-hot grant: sticky error, no state change.
    rsp(2'd2, 2'd0); cyc("t6_rspfree", 1, 0, 4'b0000, 0);
    cyc("t6_sticky", 1, 0, 4'b0000, 1);
    grant(4'b0011); cyc("t6_grant", 1, 0, 4'b0000, 1);
    cyc("t6_after", 1, 0, 4'b0000, 1);
    do_reset();

    // Multi-hot grant to two READY entries is ignored.
    offer(3'd1, 3'b000); cyc("mh_a0", 1, 0, 4'b0000, 0);
    offer(3'd1, 3'b000); cyc("mh_a1", 1, 1, 4'b0001, 0);
    grant(4'b0011); cyc("mh_grant", 1, 2, 4'b0011, 0);
    cyc("mh_err", 1, 2, 4'b0011, 1);
    do_reset();

    // Illegal source slot 3.
    offer(3'd0, 3'b001); cyc("s3_a", 1, 0, 4'b0000, 0);
    rsp(2'd0, 2'd3); cyc("s3_rsp", 1, 1, 4'b0000, 0);
    cyc("s3_err", 1, 1, 4'b0000, 1);
    rsp(2'd0, 2'd0); cyc("s3_ok", 1, 1, 4'b0000, 1);
    cyc("s3_rdy", 1, 1, 4'b0001, 1);
    do_reset();

    // Last operand and grant together: grant is an error, entry still becomes READY.
    offer(3'd1, 3'b001); cyc("pc_a", 1, 0, 4'b0000, 0);
    rsp(2'd0, 2'd0); grant(4'b0001); cyc("pc_both", 1, 1, 4'b0000, 0);
    cyc("pc_err", 1, 1, 4'b0001, 1);
    grant(4'b0001); cyc("pc_g", 1, 1, 4'b0001, 1);
    cyc("pc_free", 1, 0, 4'b0000, 1);
    do_reset();

    // Flush with grant, then flush with response: both silent.
    offer(3'd7, 3'b000); cyc("fg_a", 1, 0, 4'b0000, 0);
    cyc("fg_rdy", 1, 1, 4'b0001, 0);
    flush(3'd7); grant(4'b0001); cyc("fg_both", 1, 1, 4'b0001, 0);
    cyc("fg_post", 1, 0, 4'b0000, 0);
    offer(3'd7, 3'b011); cyc("fr_a", 1, 0, 4'b0000, 0);
    rsp(2'd0, 2'd0); flush(3'd7); cyc("fr_both", 1, 1, 4'b0000, 0);
    cyc("fr_post", 1, 0, 4'b0000, 0);

    // Response to a non-pending source bit.
    offer(3'd2, 3'b010); cyc("np_a", 1, 0, 4'b0000, 0);
    rsp(2'd0, 2'd0); cyc("np_rsp", 1, 1, 4'b0000, 0);
    cyc("np_err", 1, 1, 4'b0000, 1);

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/oc_alloc_ctrl.md
# oc_alloc_ctrl

Allocation and sequencing controller for the four operand-collector (OC) entries that feed the EX issue arbiter. Accepts one decoded instruction per cycle from the warp issue stage, assigns it to a free OC entry, tracks outstanding register-file source reads per entry, and raises the per-entry issue request toward the EX issue arbiter once all operands are collected. On grant it retires the entry. It also supports per-warp flush of entries not yet issued.

## Interface
- WARP_ID_W, 3: width of warp ID fields.
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- Iss_Valid  in  1  new instruction offered by the warp issue stage.
- Iss_Warp_ID  in  WARP_ID_W  warp of offered instruction.
- Iss_Src_Valid  in  3  bitmask of source operands that need a register-file read (src0..src2).
- Iss_Ready  out  1  at least one entry FREE; the transfer happens on Iss_Valid & Iss_Ready.
- Alloc_Entry  out  2  index of entry receiving the instruction this cycle; valid when Iss_Valid & Iss_Ready.
- RF_Rsp_Valid  in  1  one register-file read response this cycle.
- RF_Rsp_Entry  in  2  target entry of the response.
- RF_Rsp_Src  in  2  source slot 0..2 of the response; 3 is illegal.
- OC_IssReq_EX_IU  out  4  per-entry issue request to the EX issue arbiter.
- EX_IU_Grant  in  4  one-hot grant from the EX issue arbiter, already registered and already masked by MSHR_Done.
- Flush_Valid  in  1  flush request.
- Flush_Warp_ID  in  WARP_ID_W  warp to flush.
- OC_Err  out  1  sticky protocol-error flag.

## Operation
- Per-entry registers: state (FREE, COLLECTING, READY), Pending[2:0], Warp_ID.
- Allocation: lowest-index FREE entry. On Iss_Valid & Iss_Ready:
  - Warp_ID <= Iss_Warp_ID.
  - Pending <= Iss_Src_Valid.
  - State <= COLLECTING if Iss_Src_Valid != 0, otherwise READY.
- Response: on RF_Rsp_Valid with a COLLECTING target entry and the Pending bit set, that bit clears. When the cleared bit is the last one set, the entry goes to READY at the same edge.
- OC_IssReq_EX_IU[i] = (state[i] == READY), decoded from registers only (no combinational path from inputs).
- Grant: EX_IU_Grant[i] with entry i READY sends the entry to FREE at that edge. The entry holds READY and keeps requesting until granted. A grant suppressed by the arbiter during MSHR_Done leaves the entry untouched.
- Flush: on Flush_Valid, every COLLECTING or READY entry whose Warp_ID equals Flush_Warp_ID goes to FREE and its Pending is cleared.
- OC_Err sets and holds until reset on any of these:
  - a grant to a non-READY entry;
  - a response to a non-COLLECTING entry, to a non-pending bit, or with RF_Rsp_Src == 3;
  - EX_IU_Grant not one-hot-or-zero.
- The offending event is otherwise ignored.

## Timing
- Reset: all entries FREE, Pending = 0, Warp_ID = 0. Iss_Ready = 1, Alloc_Entry = 0, OC_IssReq_EX_IU = 0, OC_Err = 0.
- Iss_Ready and Alloc_Entry are combinational from registered state only.
- Allocation with Iss_Src_Valid = 0: request asserts on the cycle after acceptance (1-cycle latency).
- Allocation with sources: request asserts on the cycle after the final response.
- Grant at edge N: request deasserts after edge N. The freed entry is visible in Iss_Ready and allocatable from cycle N+1. There is no same-cycle free-and-reallocate.
- Simultaneous events on the same entry, in order of precedence:
  - Flush with a grant: FREE, no error.
  - Flush with a response: FREE, no error.
  - Response completing the last operand with a grant: grant is an error because the entry is not yet READY; the entry still goes READY.
- Flush and allocation in the same cycle with a matching warp: the newly allocated entry is NOT flushed.
- All four entries busy: Iss_Ready = 0. Iss_Valid is held by the producer; nothing is dropped.
- rst_n asserted mid-operation clears everything immediately. In-flight responses after reset release set OC_Err.

## Test plan
- Reset, then offer warp 2 with Src = 3'b000 -> Alloc_Entry = 0, OC_IssReq = 4'b0001 next cycle. Grant 4'b0001 -> request 0 the following cycle, Iss_Ready stays 1.
- Allocate four instructions with Src = 3'b111 on consecutive cycles -> Alloc_Entry 0,1,2,3 and Iss_Ready = 0 after the fourth. Return responses for entry 2 src0..2 -> OC_IssReq = 4'b0100 after the third response.
- All entries READY, grant 4'b0010 -> entry 1 FREE and Iss_Ready = 1 next cycle. A new offer then gets Alloc_Entry = 1.
- Entries 0 and 2 warp 5 (COLLECTING and READY), entry 1 warp 3. Flush_Warp_ID = 5 -> entries 0 and 2 FREE, entry 1 unchanged, OC_Err = 0.
- Hold READY entry 3 ungranted for 5 cycles (MSHR_Done stall at the arbiter) -> OC_IssReq[3] stays 1 throughout. Grant later -> normal retire.
- Response to a FREE entry, then grant 4'b0011 -> OC_Err = 1 and stays 1. Entry states unchanged by the illegal events.
